// File: rtl/maze_game_engine.sv
// Per-frame game-state engine for the tilt maze: maps tilt to velocity, scans a wall snapshot
// one wall per clock, then resolves border/wall/goal/timeout and updates position, timer and score.
module maze_game_engine #(
  parameter int GRID_W         = 5,
  parameter int GRID_H         = 5,
  parameter int CELL           = 80,
  parameter int ORIGIN_X       = 120,
  parameter int ORIGIN_Y       = 0,
  parameter int WALL_T         = 2,
  parameter int PWIDTH         = 20,
  parameter int START_X        = 130,
  parameter int START_Y        = 330,
  parameter int GOAL_X         = 460,
  parameter int GOAL_Y         = 20,
  parameter int GOAL_W         = 30,
  parameter int GOAL_H         = 20,
  parameter int DEAD           = 1,
  parameter int GAIN_SH        = 1,
  parameter int VMAX           = 2,
  parameter int SWAP_XY        = 1,
  parameter int INV_X          = 1,
  parameter int INV_Y          = 0,
  parameter int TIME_START     = 30,
  parameter int FRAMES_PER_SEC = 60,
  parameter int TIMER_W        = 6
) (
  input  logic                       in_clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic                       run,
  input  logic                       restart,
  input  logic signed [4:0]          tilt_x,
  input  logic signed [4:0]          tilt_y,
  input  logic [GRID_W*GRID_H-1:0]   h_walls,
  input  logic [GRID_W*GRID_H-1:0]   v_walls,
  output logic [10:0]                px,
  output logic [10:0]                py,
  output logic [TIMER_W-1:0]         timer,
  output logic [15:0]                score,
  output logic                       busy,
  output logic                       collision_p,
  output logic                       goal_p,
  output logic                       timeout_p,
  output logic                       overrun
);

  localparam int N  = GRID_W * GRID_H;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] I_LAST = KW'(GRID_W - 1);
  localparam logic [KW-1:0] J_LAST = KW'(GRID_H - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_SEC - 1);

  localparam logic signed [12:0] OX    = 13'(ORIGIN_X);
  localparam logic signed [12:0] OY    = 13'(ORIGIN_Y);
  localparam logic signed [12:0] CL    = 13'(CELL);
  localparam logic signed [12:0] WT    = 13'(WALL_T);
  localparam logic signed [12:0] PW1   = 13'(PWIDTH - 1);
  localparam logic signed [12:0] X_MAX = 13'(ORIGIN_X + GRID_W * CELL - 1);
  localparam logic signed [12:0] Y_MAX = 13'(ORIGIN_Y + GRID_H * CELL - 1);
  localparam logic signed [12:0] GX_LO = 13'(GOAL_X);
  localparam logic signed [12:0] GX_HI = 13'(GOAL_X + GOAL_W - 1);
  localparam logic signed [12:0] GY_LO = 13'(GOAL_Y);
  localparam logic signed [12:0] GY_HI = 13'(GOAL_Y + GOAL_H - 1);

  localparam logic [10:0]         SX     = 11'(START_X);
  localparam logic [10:0]         SY     = 11'(START_Y);
  localparam logic [TIMER_W-1:0]  T_LOAD = TIMER_W'(TIME_START);
  localparam logic [TIMER_W-1:0]  T_ONE  = TIMER_W'(1);
  localparam logic signed [11:0]  DEAD_V = 12'(DEAD);
  localparam logic signed [11:0]  VMAX_V = 12'(VMAX);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SCAN, S_RESOLVE} state_t;

  state_t state, state_n;

  logic signed [12:0] cand_x, cand_y;
  logic signed [12:0] xb, yb;
  logic [KW-1:0]      k, ci, cj;
  logic               vert, hit;
  logic [N-1:0]       h_snap, v_snap;
  logic [FW-1:0]      fcnt;

  logic signed [11:0] vel_tx, vel_ty, vx, vy;
  logic signed [12:0] wx_lo, wx_hi, wy_lo, wy_hi;
  logic               wall_bit, wall_hit, border_hit, goal_hit, scan_last;

  // Deadzone, shift-and-offset gain, then clamp; the sign is reapplied at the end.
  function automatic logic signed [11:0] tilt_to_vel(input logic signed [4:0] t);
    logic signed [11:0] ts, mag, spd;
    ts  = {{7{t[4]}}, t};
    mag = ts[11] ? -ts : ts;
    if (mag <= DEAD_V) begin
      spd = '0;
    end else begin
      spd = ((mag - DEAD_V) >>> GAIN_SH) + 12'sd1;
      if (spd > VMAX_V) spd = VMAX_V;
    end
    return ts[11] ? -spd : spd;
  endfunction

  assign vel_tx = tilt_to_vel(tilt_x);
  assign vel_ty = tilt_to_vel(tilt_y);

  always_comb begin
    vx = (SWAP_XY != 0) ? vel_ty : vel_tx;
    vy = (SWAP_XY != 0) ? vel_tx : vel_ty;
    if (INV_X != 0) vx = -vx;
    if (INV_Y != 0) vy = -vy;
  end

  // Bounds of the wall under the scan pointer; xb/yb track the current cell's top-left corner.
  always_comb begin
    wx_lo    = vert ? (xb + CL - WT) : xb;
    wx_hi    = xb + CL - 13'sd1;
    wy_lo    = vert ? yb : (yb + CL - WT);
    wy_hi    = yb + CL - 13'sd1;
    wall_bit = vert ? v_snap[k] : h_snap[k];
    wall_hit = wall_bit && (cand_x <= wx_hi) && (cand_x + PW1 >= wx_lo)
                        && (cand_y <= wy_hi) && (cand_y + PW1 >= wy_lo);
  end

  assign border_hit = (cand_x < OX) || (cand_x + PW1 > X_MAX)
                   || (cand_y < OY) || (cand_y + PW1 > Y_MAX);
  assign goal_hit   = (cand_x <= GX_HI) && (cand_x + PW1 >= GX_LO)
                   && (cand_y <= GY_HI) && (cand_y + PW1 >= GY_LO);
  assign scan_last  = vert && (k == K_LAST);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge in_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    // NOTE: next state gets its default before any branch, so no path can infer a latch.
    state_n = state;
    if (restart) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (frame_tick && run) state_n = S_LATCH;
        S_LATCH:   state_n = S_SCAN;
        S_SCAN:    if (scan_last) state_n = S_RESOLVE;
        S_RESOLVE: state_n = S_IDLE;
        default:   state_n = S_IDLE;
      endcase
    end
  end

  // NOTE: the wall snapshots carry no reset; LATCH always rewrites them before SCAN reads them.
  always_ff @(posedge in_clk) begin
    if (state == S_LATCH) begin
      h_snap <= h_walls;
      v_snap <= v_walls;
    end
  end

  always_ff @(posedge in_clk) begin
    // NOTE: all sequential state uses <= so every register sees the pre-edge values.
    if (reset) begin
      px          <= SX;
      py          <= SY;
      timer       <= T_LOAD;
      score       <= '0;
      fcnt        <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      hit         <= 1'b0;
      k           <= '0;
      ci          <= '0;
      cj          <= '0;
      xb          <= OX;
      yb          <= OY;
      vert        <= 1'b0;
      collision_p <= 1'b0;
      goal_p      <= 1'b0;
      timeout_p   <= 1'b0;
    end else if (restart) begin
      px          <= SX;
      py          <= SY;
      timer       <= T_LOAD;
      fcnt        <= '0;
      hit         <= 1'b0;
      collision_p <= 1'b0;
      goal_p      <= 1'b0;
      timeout_p   <= 1'b0;
    end else begin
      collision_p <= 1'b0;
      goal_p      <= 1'b0;
      timeout_p   <= 1'b0;
      case (state)
        S_LATCH: begin
          cand_x <= $signed({2'b00, px}) + $signed({vx[11], vx});
          cand_y <= $signed({2'b00, py}) + $signed({vy[11], vy});
          hit    <= 1'b0;
          k      <= '0;
          ci     <= '0;
          cj     <= '0;
          xb     <= OX;
          yb     <= OY;
          vert   <= 1'b0;
        end
        S_SCAN: begin
          hit <= hit | wall_hit;
          k   <= (k == K_LAST) ? '0 : k + 1'b1;
          if (ci == I_LAST) begin
            ci <= '0;
            xb <= OX;
            if (cj == J_LAST) begin
              cj   <= '0;
              yb   <= OY;
              vert <= 1'b1;
            end else begin
              cj <= cj + 1'b1;
              yb <= yb + CL;
            end
          end else begin
            ci <= ci + 1'b1;
            xb <= xb + CL;
          end
        end
        S_RESOLVE: begin
          if (hit || border_hit) begin
            px          <= SX;
            py          <= SY;
            timer       <= T_LOAD;
            fcnt        <= '0;
            collision_p <= 1'b1;
          end else if (goal_hit) begin
            px     <= SX;
            py     <= SY;
            timer  <= T_LOAD;
            score  <= (score == 16'hFFFF) ? score : score + 16'd1;
            goal_p <= 1'b1;
          end else if (fcnt == F_LAST) begin
            fcnt <= '0;
            if (timer == T_ONE) begin
              px        <= SX;
              py        <= SY;
              timer     <= T_LOAD;
              timeout_p <= 1'b1;
            end else begin
              px    <= cand_x[10:0];
              py    <= cand_y[10:0];
              timer <= timer - T_ONE;
            end
          end else begin
            px   <= cand_x[10:0];
            py   <= cand_y[10:0];
            fcnt <= fcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset)                overrun <= 1'b0;
    else if (frame_tick && busy) overrun <= 1'b1;
  end

endmodule
